flash_loader: RTL and testbench
===============================

# flash_loader

UART-to-serial-flash programmer for the CoPro design, the write-side counterpart of the boot-time flash dump/print path. It takes command frames from the JTAG UART receive side and drives the serial flash controller's sector-erase and page-program port. It returns one status byte per frame over the JTAG UART transmit side. Sits between `jtag_uart` and the ASMI-style flash controller, alongside the existing read path.

## Interface
- `TIMEOUT_CYCLES`, 33_000_000: max idle cycles between bytes inside a frame (1 s at 33 MHz).
- `clk_i` in 1: system clock (sysclk).
- `nreset_i` in 1: reset, asynchronous, active-low; one clock, no other clock domains.
- `uart_rxmt_i` in 1: UART RX FIFO empty.
- `uart_data_i` in 8: UART RX data, valid the cycle after `uart_rd_o`.
- `uart_rd_o` out 1: RX pop strobe, one cycle.
- `uart_txfl_i` in 1: UART TX FIFO full.
- `uart_data_o` out 8: TX byte.
- `uart_nwr_o` out 1: TX write strobe, active-low, one cycle.
- `flash_addr_o` out 24: erase/program start address.
- `flash_datain_o` out 8: byte to shift into the page buffer.
- `flash_shift_bytes_o`, `flash_wren_o`, `flash_write_o`, `flash_sector_erase_o` out 1: controller strobes.
- `flash_busy_i`, `flash_illegal_write_i`, `flash_illegal_erase_i` in 1: controller status.

## Operation
- Frames, big-endian address:
  - `'E'`(0x45), A2, A1, A0: erase sector.
  - `'W'`(0x57), A2, A1, A0, N, then N data bytes: program page. N = 0 means 256 bytes.
- Reply is one byte: `'K'`(0x4B) on success, `'!'`(0x21) on any error.
- Errors: unknown command byte, illegal flag, inter-byte timeout. Unknown command gets `'!'` immediately; the frame is not consumed further.
- States:
  - IDLE → GET (command) → ADDR ×3 → {ERASE | LEN → DATA ×N → PROG} → WAIT_BUSY → REPLY → IDLE.
  - GET is the shared byte-fetch substate: request → latch.
- Byte counter is 9 bits. It loads N (0 → 256) and decrements per shifted byte; PROG is entered at 0.
- DATA: each byte is presented on `flash_datain_o` with `flash_shift_bytes_o`=`flash_wren_o`=1 for exactly one cycle.
- PROG: `flash_write_o`=`flash_wren_o`=1 for one cycle. ERASE: `flash_sector_erase_o`=`flash_wren_o`=1 for one cycle.
- `flash_addr_o` holds the frame address from the end of ADDR until IDLE.
- The page-wrap rule (address low byte + N > 256) is not checked; it is left to the flash.
- WAIT_BUSY:
  - Ignores `flash_busy_i` for 2 cycles, then waits for `flash_busy_i`=0.
  - Either `flash_illegal_*_i` seen high at any cycle in WAIT_BUSY latches an error.
- REPLY: waits for `uart_txfl_i`=0, drives `uart_data_o` and `uart_nwr_o`=0 for one cycle, then returns to IDLE.

## Timing
- Reset values:
  - `uart_rd_o`=0, `uart_nwr_o`=1, `uart_data_o`=0.
  - All flash strobes 0, `flash_addr_o`=0, `flash_datain_o`=0.
  - State IDLE.
- Byte fetch:
  - Cycle n: `uart_rxmt_i`=0 → `uart_rd_o`=1.
  - Cycle n+1: `uart_data_i` latched, `uart_rd_o`=0.
  - Minimum 2 cycles per byte; never two consecutive `uart_rd_o` cycles.
- Data byte latched at n+1 is shifted at n+2 (one shift per fetched byte, pipelined with the next fetch).
- Timeout:
  - Counter clears on every latched byte and counts while waiting for a byte in any non-IDLE fetch.
  - Reaching `TIMEOUT_CYCLES` → REPLY `'!'`, no flash strobe issued.
  - In DATA, `flash_write_o` is not pulsed; the page buffer is abandoned.
- Reset mid-operation: returns to IDLE immediately with outputs at reset values. A flash operation already started is not tracked.
- Simultaneous illegal flag and busy fall in the same cycle: error wins.

## Configuration
- `FLASH_LOADER_CHECKSUM_EN`:
  - Defined: for `'W'` frames, REPLY first sends the 8-bit modulo-256 sum of the N data bytes, then `'K'`/`'!'`. Each byte uses its own `txfl`-gated one-cycle `uart_nwr_o` strobe. A timed-out `'W'` sends `'!'` only.
  - Undefined: single status byte only; no sum logic.

## Test plan
- Erase: 45 02 00 00, busy high 10 cycles → one `flash_sector_erase_o`+`flash_wren_o` pulse, addr 0x020000, reply 0x4B.
- Program: 57 02 00 10 03 AA BB CC → three shift pulses with data AA, BB, CC, then one `flash_write_o`, addr 0x020010, reply 0x4B. With CHECKSUM_EN the reply is 0x31 then 0x4B.
- N=0: 57 00 01 00 00 + 256 bytes 0x00..0xFF → exactly 256 shift pulses, one write, reply 0x4B.
- Illegal: erase with `flash_illegal_erase_i` pulsed in WAIT_BUSY → reply 0x21. Unknown command 0x58 → immediate 0x21, then 0x45… is accepted normally.
- Timeout (`TIMEOUT_CYCLES`=100): 57 02 00 00 05 AA then silence → no `flash_write_o`, reply 0x21 at cycle 100 after the last latch.
- Backpressure/reset: hold `uart_txfl_i`=1 for 50 cycles → `uart_nwr_o` stays 1 until release, then one low cycle. Assert `nreset_i` mid-DATA → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/flash_loader.sv
// -----------------------------------------------------------------------------
// flash_loader
// UART-to-serial-flash programmer. Receives command frames from the JTAG UART
// RX FIFO and drives the flash controller's sector-erase / page-program port.
// One status byte per frame ('K' = ok, '!' = error) goes back on the UART TX.
//
//   'E' A2 A1 A0            : erase sector at {A2,A1,A0}
//   'W' A2 A1 A0 N d0..     : program N data bytes (N = 0 means 256)
//
// Ports
//   clk_i, nreset_i           : clock, asynchronous active-low reset
//   uart_rxmt_i, uart_data_i  : RX FIFO empty flag / data (valid cycle after rd)
//   uart_rd_o                 : RX pop strobe (one cycle)
//   uart_txfl_i               : TX FIFO full
//   uart_data_o, uart_nwr_o   : TX byte / active-low write strobe
//   flash_addr_o              : erase/program start address
//   flash_datain_o            : byte shifted into the page buffer
//   flash_shift_bytes_o, flash_wren_o, flash_write_o, flash_sector_erase_o
//                             : controller strobes (one cycle each)
//   flash_busy_i, flash_illegal_write_i, flash_illegal_erase_i
//                             : controller status
//
// Configuration macro: FLASH_LOADER_CHECKSUM_EN
//   When defined, a 'W' frame that did not time out replies with the modulo-256
//   sum of its data bytes first, followed by the status byte.
// -----------------------------------------------------------------------------
module flash_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 33_000_000
) (
   input  logic        clk_i,
   input  logic        nreset_i,
   input  logic        uart_rxmt_i,
   input  logic [7:0]  uart_data_i,
   output logic        uart_rd_o,
   input  logic        uart_txfl_i,
   output logic [7:0]  uart_data_o,
   output logic        uart_nwr_o,
   output logic [23:0] flash_addr_o,
   output logic [7:0]  flash_datain_o,
   output logic        flash_shift_bytes_o,
   output logic        flash_wren_o,
   output logic        flash_write_o,
   output logic        flash_sector_erase_o,
   input  logic        flash_busy_i,
   input  logic        flash_illegal_write_i,
   input  logic        flash_illegal_erase_i
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CMD_ERASE = 8'h45;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h21;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RD, S_LATCH, S_ERASE, S_PROG, S_WAIT_BUSY, S_REPLY
   } state_e;

   // Which frame byte the shared fetch substate is currently collecting.
   typedef enum logic [2:0] {
      F_CMD, F_A2, F_A1, F_A0, F_LEN, F_DATA
   } field_e;

`ifdef FLASH_LOADER_CHECKSUM_EN
   function automatic logic [7:0] sum8_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction
`endif

   state_e        state_q, state_d;
   field_e        field_q, field_d;
   logic          is_w_q, is_w_d;
   logic          err_q, err_d;
   logic [8:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    wb_q, wb_d;
   logic          rd_q, rd_d;
   logic          nwr_q, nwr_d;
   logic [7:0]    txd_q, txd_d;
   logic [23:0]   addr_q, addr_d;
   logic [7:0]    din_q, din_d;
   logic          shift_q, shift_d;
   logic          wren_q, wren_d;
   logic          write_q, write_d;
   logic          erase_q, erase_d;
   logic          more_s;
`ifdef FLASH_LOADER_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
   logic          sum_pend_q, sum_pend_d;
`endif

   assign uart_rd_o            = rd_q;
   assign uart_nwr_o           = nwr_q;
   assign uart_data_o          = txd_q;
   assign flash_addr_o         = addr_q;
   assign flash_datain_o       = din_q;
   assign flash_shift_bytes_o  = shift_q;
   assign flash_wren_o         = wren_q;
   assign flash_write_o        = write_q;
   assign flash_sector_erase_o = erase_q;

   // Next-state and registered-output logic for the frame FSM.
   always_comb begin
      state_d  = state_q;
      field_d  = field_q;
      is_w_d   = is_w_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      wb_d     = wb_q;
      txd_d    = txd_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rd_d     = 1'b0;
      nwr_d    = 1'b1;
      shift_d  = 1'b0;
      wren_d   = 1'b0;
      write_d  = 1'b0;
      erase_d  = 1'b0;
      more_s   = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
      sum_pend_d = sum_pend_q;
`endif

      case (state_q)
         S_IDLE: begin
            field_d = F_CMD;
            is_w_d  = 1'b0;
            err_d   = 1'b0;
            tmo_d   = '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            sum_d      = 8'h00;
            sum_pend_d = 1'b0;
`endif
            // No timeout while waiting for a command byte.
            if (!uart_rxmt_i) begin
               rd_d    = 1'b1;
               state_d = S_RD;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_REQ: begin
            if (!uart_rxmt_i) begin
               rd_d    = 1'b1;
               state_d = S_RD;
            end else if (tmo_q == TMO_LAST) begin
               // Abandon the frame; no flash strobe follows a timeout.
               err_d   = 1'b1;
               state_d = S_REPLY;
`ifdef FLASH_LOADER_CHECKSUM_EN
               sum_pend_d = 1'b0;
`endif
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         // Pop strobe is visible this cycle; data arrives next cycle.
         S_RD: begin
            state_d = S_LATCH;
         end

         S_LATCH: begin
            tmo_d = '0;
            case (field_q)
               F_CMD: begin
                  if (uart_data_i == CMD_ERASE) begin
                     is_w_d  = 1'b0;
                     field_d = F_A2;
                     more_s  = 1'b1;
                  end else if (uart_data_i == CMD_WRITE) begin
                     is_w_d  = 1'b1;
                     field_d = F_A2;
                     more_s  = 1'b1;
                  end else begin
                     // Unknown command: reply at once, rest of frame untouched.
                     err_d   = 1'b1;
                     state_d = S_REPLY;
                  end
               end
               F_A2: begin
                  addr_d  = {uart_data_i, addr_q[15:0]};
                  field_d = F_A1;
                  more_s  = 1'b1;
               end
               F_A1: begin
                  addr_d  = {addr_q[23:16], uart_data_i, addr_q[7:0]};
                  field_d = F_A0;
                  more_s  = 1'b1;
               end
               F_A0: begin
                  addr_d = {addr_q[23:8], uart_data_i};
                  if (is_w_q) begin
                     field_d = F_LEN;
                     more_s  = 1'b1;
                  end else begin
                     state_d = S_ERASE;
                  end
               end
               F_LEN: begin
                  cnt_d   = (uart_data_i == 8'h00) ? 9'd256 : {1'b0, uart_data_i};
                  field_d = F_DATA;
                  more_s  = 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
                  sum_pend_d = 1'b1;
`endif
               end
               F_DATA: begin
                  // Shift happens next cycle, overlapped with the next fetch.
                  din_d   = uart_data_i;
                  shift_d = 1'b1;
                  wren_d  = 1'b1;
                  cnt_d   = cnt_q - 9'd1;
`ifdef FLASH_LOADER_CHECKSUM_EN
                  sum_d = sum8_add(sum_q, uart_data_i);
`endif
                  if (cnt_q == 9'd1) begin
                     state_d = S_PROG;
                  end else begin
                     more_s = 1'b1;
                  end
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = S_REPLY;
               end
            endcase
            // Chain straight into the next pop when a byte is already waiting.
            if (more_s) begin
               if (!uart_rxmt_i) begin
                  rd_d    = 1'b1;
                  state_d = S_RD;
               end else begin
                  state_d = S_REQ;
               end
            end else begin
               rd_d = 1'b0;
            end
         end

         S_ERASE: begin
            erase_d = 1'b1;
            wren_d  = 1'b1;
            wb_d    = 2'd0;
            state_d = S_WAIT_BUSY;
         end

         S_PROG: begin
            write_d = 1'b1;
            wren_d  = 1'b1;
            wb_d    = 2'd0;
            state_d = S_WAIT_BUSY;
         end

         S_WAIT_BUSY: begin
            if (flash_illegal_write_i || flash_illegal_erase_i) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            // Busy is not yet valid during the first two cycles after the strobe.
            if (wb_q != 2'd2) begin
               wb_d = wb_q + 2'd1;
            end else if (!flash_busy_i) begin
               state_d = S_REPLY;
            end else begin
               state_d = S_WAIT_BUSY;
            end
         end

         S_REPLY: begin
            // Requiring nwr_q high keeps back-to-back bytes as separate strobes.
            if (!uart_txfl_i && nwr_q) begin
               nwr_d = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
               if (sum_pend_q) begin
                  txd_d      = sum_q;
                  sum_pend_d = 1'b0;
               end else begin
                  txd_d   = err_q ? RSP_ERR : RSP_OK;
                  state_d = S_IDLE;
               end
`else
               txd_d   = err_q ? RSP_ERR : RSP_OK;
               state_d = S_IDLE;
`endif
            end else begin
               nwr_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= S_IDLE;
         field_q <= F_CMD;
         is_w_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 9'd0;
         tmo_q   <= '0;
         wb_q    <= 2'd0;
         rd_q    <= 1'b0;
         nwr_q   <= 1'b1;
         txd_q   <= 8'h00;
         addr_q  <= 24'h000000;
         din_q   <= 8'h00;
         shift_q <= 1'b0;
         wren_q  <= 1'b0;
         write_q <= 1'b0;
         erase_q <= 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
         sum_q      <= 8'h00;
         sum_pend_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         is_w_q  <= is_w_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         wb_q    <= wb_d;
         rd_q    <= rd_d;
         nwr_q   <= nwr_d;
         txd_q   <= txd_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         shift_q <= shift_d;
         wren_q  <= wren_d;
         write_q <= write_d;
         erase_q <= erase_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
         sum_pend_q <= sum_pend_d;
`endif
      end
   end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: table of frames plus hand-written
// timeout, TX backpressure and mid-frame reset sequences.
module tb_flash_loader;

   localparam int TMO = 100;

   logic        clk_i = 1'b0;
   logic        nreset_i;
   logic        uart_rxmt_i;
   logic [7:0]  uart_data_i;
   logic        uart_rd_o;
   logic        uart_txfl_i;
   logic [7:0]  uart_data_o;
   logic        uart_nwr_o;
   logic [23:0] flash_addr_o;
   logic [7:0]  flash_datain_o;
   logic        flash_shift_bytes_o;
   logic        flash_wren_o;
   logic        flash_write_o;
   logic        flash_sector_erase_o;
   logic        flash_busy_i;
   logic        flash_illegal_write_i;
   logic        flash_illegal_erase_i;

   flash_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i                 (clk_i),
      .nreset_i              (nreset_i),
      .uart_rxmt_i           (uart_rxmt_i),
      .uart_data_i           (uart_data_i),
      .uart_rd_o             (uart_rd_o),
      .uart_txfl_i           (uart_txfl_i),
      .uart_data_o           (uart_data_o),
      .uart_nwr_o            (uart_nwr_o),
      .flash_addr_o          (flash_addr_o),
      .flash_datain_o        (flash_datain_o),
      .flash_shift_bytes_o   (flash_shift_bytes_o),
      .flash_wren_o          (flash_wren_o),
      .flash_write_o         (flash_write_o),
      .flash_sector_erase_o  (flash_sector_erase_o),
      .flash_busy_i          (flash_busy_i),
      .flash_illegal_write_i (flash_illegal_write_i),
      .flash_illegal_erase_i (flash_illegal_erase_i)
   );

   initial forever #5 clk_i = ~clk_i;

   typedef struct {
      string      name;
      logic [7:0] cmd;
      logic [23:0] addr;
      int         n;
      logic [7:0] d0;
      logic [7:0] dstep;
      bit         ill;
      int         busy_cyc;
      logic [7:0] reply;
   } vec_t;

   vec_t vq[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_tx[$];
   logic [7:0] exp_shift[$];
   int n_shift = 0, n_write = 0, n_erase = 0, n_tx = 0;
   logic [23:0] strobe_addr = 24'h0;
   int last_rd_cyc = 0, last_tx_cyc = 0;
   int cur_busy = 0;
   bit cur_ill = 1'b0;
   bit ill_pending = 1'b0, ill_is_erase = 1'b0;
   int busy_left = 0;
   bit prev_rd = 1'b0, prev_nwr_low = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [7:0] cmd, input logic [23:0] addr,
                          input int n, input logic [7:0] d0, input logic [7:0] dstep,
                          input bit ill, input int busy_cyc, input logic [7:0] reply);
      vec_t v;
      v.name = name; v.cmd = cmd; v.addr = addr; v.n = n; v.d0 = d0; v.dstep = dstep;
      v.ill = ill; v.busy_cyc = busy_cyc; v.reply = reply;
      vq.push_back(v);
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // UART FIFO, flash controller model and output monitors, all at negedge.
   initial begin
      uart_rxmt_i = 1'b1;
      uart_data_i = 8'h00;
      flash_busy_i = 1'b0;
      flash_illegal_write_i = 1'b0;
      flash_illegal_erase_i = 1'b0;
      forever begin
         @(negedge clk_i);
         // RX FIFO: pop on rd strobe, data valid from here through next cycle.
         if (uart_rd_o) begin
            check("rd_not_back_to_back", 32'(prev_rd), 32'd0);
            check("rd_fifo_nonempty", 32'(rx_q.size() > 0), 32'd1);
            if (rx_q.size() > 0) uart_data_i = rx_q.pop_front();
            last_rd_cyc = cyc;
         end
         prev_rd = uart_rd_o;
         uart_rxmt_i = (rx_q.size() == 0);
         // TX scoreboard.
         if (!uart_nwr_o) begin
            n_tx++;
            last_tx_cyc = cyc;
            check("nwr_one_cycle", 32'(prev_nwr_low), 32'd0);
            check("reply_after_busy", 32'(flash_busy_i), 32'd0);
            check("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
            if (exp_tx.size() > 0) check("tx_byte", 32'(uart_data_o), 32'(exp_tx.pop_front()));
         end
         prev_nwr_low = !uart_nwr_o;
         // Flash controller.
         flash_illegal_erase_i = 1'b0;
         flash_illegal_write_i = 1'b0;
         if (ill_pending) begin
            if (ill_is_erase) flash_illegal_erase_i = 1'b1;
            else flash_illegal_write_i = 1'b1;
            ill_pending = 1'b0;
         end
         if (busy_left > 0) busy_left--;
         if (flash_shift_bytes_o) begin
            n_shift++;
            check("shift_wren", 32'(flash_wren_o), 32'd1);
            check("shift_expected", 32'(exp_shift.size() > 0), 32'd1);
            if (exp_shift.size() > 0) check("shift_data", 32'(flash_datain_o), 32'(exp_shift.pop_front()));
         end
         if (flash_write_o || flash_sector_erase_o) begin
            if (flash_write_o) n_write++;
            if (flash_sector_erase_o) n_erase++;
            check("strobe_wren", 32'(flash_wren_o), 32'd1);
            strobe_addr = flash_addr_o;
            busy_left = cur_busy;
            ill_pending = cur_ill;
            ill_is_erase = flash_sector_erase_o;
         end
         flash_busy_i = (busy_left > 0);
      end
   end

   task automatic wait_tx(input string name, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_i);
         if (n_tx >= target) break;
      end
      repeat (4) @(posedge clk_i);
      check({name, "_reply_count"}, n_tx, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd"},     32'(uart_rd_o), 32'd0);
      check({tag, "_nwr"},    32'(uart_nwr_o), 32'd1);
      check({tag, "_txdata"}, 32'(uart_data_o), 32'd0);
      check({tag, "_addr"},   32'(flash_addr_o), 32'd0);
      check({tag, "_datain"}, 32'(flash_datain_o), 32'd0);
      check({tag, "_strobes"},
            32'({flash_shift_bytes_o, flash_wren_o, flash_write_o, flash_sector_erase_o}), 32'd0);
   endtask

   task automatic run_frame(input vec_t v);
      int nb, target, sh0, wr0, er0;
      logic [7:0] d, sum;
      bit is_e, is_w;
      is_e = (v.cmd == 8'h45);
      is_w = (v.cmd == 8'h57);
      nb = (v.n == 0) ? 256 : v.n;
      sh0 = n_shift; wr0 = n_write; er0 = n_erase;
      cur_busy = v.busy_cyc;
      cur_ill = v.ill;
      target = n_tx + 1;
      sum = 8'h00;
      d = v.d0;
      rx_q.push_back(v.cmd);
      if (is_e || is_w) begin
         rx_q.push_back(v.addr[23:16]);
         rx_q.push_back(v.addr[15:8]);
         rx_q.push_back(v.addr[7:0]);
      end
      if (is_w) begin
         rx_q.push_back(8'(v.n));
         for (int i = 0; i < nb; i++) begin
            rx_q.push_back(d);
            exp_shift.push_back(d);
            sum = sum + d;
            d = d + v.dstep;
         end
`ifdef FLASH_LOADER_CHECKSUM_EN
         exp_tx.push_back(sum);
         target++;
`endif
      end
      exp_tx.push_back(v.reply);
      wait_tx(v.name, target, 3000);
      check({v.name, "_shifts"}, n_shift - sh0, is_w ? nb : 0);
      check({v.name, "_writes"}, n_write - wr0, is_w ? 1 : 0);
      check({v.name, "_erases"}, n_erase - er0, is_e ? 1 : 0);
      if (is_e || is_w) check({v.name, "_addr"}, 32'(strobe_addr), 32'(v.addr));
   endtask

   initial begin
      int sh0, wr0, tx0, lat;
      nreset_i = 1'b0;
      uart_txfl_i = 1'b0;

      //       name            cmd    addr        n    d0     step   ill  busy reply
      add_vec("erase",        8'h45, 24'h020000,  0, 8'h00, 8'h00, 1'b0, 10, 8'h4B);
      add_vec("prog3",        8'h57, 24'h020010,  3, 8'hAA, 8'h11, 1'b0,  6, 8'h4B);
      add_vec("prog256",      8'h57, 24'h000100,  0, 8'h00, 8'h01, 1'b0,  8, 8'h4B);
      add_vec("erase_illegal",8'h45, 24'h030000,  0, 8'h00, 8'h00, 1'b1,  5, 8'h21);
      add_vec("prog_illegal", 8'h57, 24'h040080,  2, 8'h10, 8'h05, 1'b1,  0, 8'h21);
      add_vec("unknown_cmd",  8'h58, 24'h000000,  0, 8'h00, 8'h00, 1'b0,  0, 8'h21);
      add_vec("erase_after",  8'h45, 24'h123456,  0, 8'h00, 8'h00, 1'b0,  3, 8'h4B);
      add_vec("prog1",        8'h57, 24'hABCDEF,  1, 8'h5A, 8'h00, 1'b0,  0, 8'h4B);

      repeat (3) @(negedge clk_i);
      check_reset_outputs("por");
      nreset_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check_reset_outputs("idle");

      foreach (vq[i]) run_frame(vq[i]);

      // Inter-byte timeout inside DATA: no program strobe, '!' only.
      sh0 = n_shift; wr0 = n_write; tx0 = n_tx;
      cur_busy = 0; cur_ill = 1'b0;
      rx_q.push_back(8'h57); rx_q.push_back(8'h02); rx_q.push_back(8'h00);
      rx_q.push_back(8'h00); rx_q.push_back(8'h05); rx_q.push_back(8'hAA);
      exp_shift.push_back(8'hAA);
      exp_tx.push_back(8'h21);
      wait_tx("timeout", tx0 + 1, 400);
      check("timeout_shifts", n_shift - sh0, 1);
      check("timeout_no_write", n_write - wr0, 0);
      lat = last_tx_cyc - last_rd_cyc;
      check("timeout_latency", 32'((lat >= TMO) && (lat <= TMO + 6)), 32'd1);

      // TX backpressure: strobe held off while the FIFO reports full.
      @(negedge clk_i);
      uart_txfl_i = 1'b1;
      tx0 = n_tx;
      cur_busy = 2;
      rx_q.push_back(8'h45); rx_q.push_back(8'h01); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
      exp_tx.push_back(8'h4B);
      repeat (50) @(negedge clk_i);
      check("bp_held_while_full", n_tx - tx0, 0);
      check("bp_nwr_high", 32'(uart_nwr_o), 32'd1);
      uart_txfl_i = 1'b0;
      wait_tx("bp_release", tx0 + 1, 50);
      check("bp_addr", 32'(strobe_addr), 32'h010000);

      // Asynchronous reset in the middle of a 200-byte DATA phase.
      sh0 = n_shift;
      cur_busy = 0;
      rx_q.push_back(8'h57); rx_q.push_back(8'h05); rx_q.push_back(8'h00);
      rx_q.push_back(8'h00); rx_q.push_back(8'd200);
      for (int i = 0; i < 200; i++) begin
         rx_q.push_back(8'(i));
         exp_shift.push_back(8'(i));
      end
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         if (n_shift - sh0 >= 5) break;
      end
      check("rst_data_started", 32'(n_shift - sh0 >= 5), 32'd1);
      #2 nreset_i = 1'b0;
      #1 check_reset_outputs("midrst");
      rx_q.delete();
      exp_shift.delete();
      exp_tx.delete();
      repeat (3) @(negedge clk_i);
      check_reset_outputs("midrst_hold");
      nreset_i = 1'b1;
      repeat (2) @(negedge clk_i);
      run_frame(vq[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
